// File: rtl/snake_timer_pkg.sv
// Shared register-map constants for the multi-channel interval timer.
// The top-level decoder and the per-channel logic both import them.
package snake_timer_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int PRESC_LSB = 8;
    localparam int PRESC_MSB = 15;

    function automatic logic [31:0] status_word(input logic run, input logic to);
        status_word = {30'b0, run, to};
    endfunction

endpackage

// File: rtl/snake_timer_channel.sv
// One timer channel: prescaler, down-counter, and the RUN/TO/CONTROL/PERIOD/SNAP registers.
// Bus writes arrive as per-register strobes already decoded by the top level.
module snake_timer_channel
    import snake_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h1D4BF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_status,
    input  logic        wr_control,
    input  logic        wr_period,
    input  logic        wr_snap,
    input  logic [31:0] writedata,
    output logic [31:0] status_rd,
    output logic [31:0] control_rd,
    output logic [31:0] period_rd,
    output logic [31:0] snap_rd,
    output logic        irq
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = RESET_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snap;
    logic [7:0]       presc;
    logic [7:0]       presc_cnt;
    logic             ito;
    logic             cont;
    logic             run;
    logic             to;
    logic             reload_pending;

    logic start;
    logic stop;
    logic tick;
    logic expire;

    assign start  = wr_control & writedata[CTRL_START];
    assign stop   = wr_control & writedata[CTRL_STOP];
    // The forced reload cycle after a PERIOD write swallows any tick.
    assign tick   = run & ~reload_pending & (presc_cnt == presc);
    assign expire = tick & (counter == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter        <= PERIOD_INIT;
            period         <= PERIOD_INIT;
            snap           <= '0;
            presc          <= '0;
            presc_cnt      <= '0;
            ito            <= 1'b0;
            cont           <= 1'b0;
            run            <= 1'b0;
            to             <= 1'b0;
            reload_pending <= 1'b0;
        end else begin
            reload_pending <= wr_period;

            if (wr_period) begin
                period <= writedata[CNT_W-1:0];
            end

            if (wr_control) begin
                ito   <= writedata[CTRL_ITO];
                cont  <= writedata[CTRL_CONT];
                presc <= writedata[PRESC_MSB:PRESC_LSB];
            end

            if (wr_snap) begin
                snap <= counter;
            end

            if (reload_pending) begin
                counter <= period;
            end else if (expire) begin
                counter <= period;
            end else if (tick) begin
                counter <= counter - 1'b1;
            end

            if (start || reload_pending) begin
                presc_cnt <= '0;
            end else if (run) begin
                presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            end

            // START overrides every reason to stop, including the forced reload.
            if (start) begin
                run <= 1'b1;
            end else if (reload_pending || stop || (expire && !cont)) begin
                run <= 1'b0;
            end

            if (expire) begin
                to <= 1'b1;
            end else if (wr_status) begin
                to <= 1'b0;
            end
        end
    end

    always_comb begin
        control_rd                      = '0;
        control_rd[CTRL_ITO]            = ito;
        control_rd[CTRL_CONT]           = cont;
        control_rd[PRESC_MSB:PRESC_LSB] = presc;
    end

    assign status_rd = status_word(run, to);
    assign period_rd = 32'(period);
    assign snap_rd   = 32'(snap);
    assign irq       = to & ito;

    generate
        if (CNT_W < 32) begin : g_narrow
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:CNT_W];
        end
    endgenerate

endmodule

// File: rtl/snake_multi_timer.sv
// N-channel interval timer on an Avalon-MM slave: address decode, registered read mux,
// and the per-channel IRQ vector with its OR-reduced line for the processor.
module snake_multi_timer
    import snake_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h1D4BF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+1:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [NUM_CH-1:0]          irq_vec,
    output logic                       irq
);

    localparam int AW   = $clog2(NUM_CH) + 2;
    localparam int CH_W = (AW > 2) ? AW - 2 : 1;

    logic [1:0]      reg_sel;
    logic [CH_W-1:0] ch_sel;
    logic            wr_en;
    logic            rd_en;
    logic [31:0]     read_value;

    logic [31:0] status_rd  [NUM_CH];
    logic [31:0] control_rd [NUM_CH];
    logic [31:0] period_rd  [NUM_CH];
    logic [31:0] snap_rd    [NUM_CH];

    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & ~write_n;
    assign rd_en   = chipselect & write_n;

    generate
        if (AW > 2) begin : g_ch_field
            assign ch_sel = address[AW-1:2];
        end else begin : g_single_ch
            assign ch_sel = '0;
        end
    endgenerate

    // Unpopulated channel indices match no instance, so their writes fall on the floor.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic ch_hit;
            assign ch_hit = wr_en & (ch_sel == CH_W'(i));

            snake_timer_channel #(
                .CNT_W        (CNT_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_channel (
                .clk        (clk),
                .reset_n    (reset_n),
                .wr_status  (ch_hit & (reg_sel == REG_STATUS)),
                .wr_control (ch_hit & (reg_sel == REG_CONTROL)),
                .wr_period  (ch_hit & (reg_sel == REG_PERIOD)),
                .wr_snap    (ch_hit & (reg_sel == REG_SNAP)),
                .writedata  (writedata),
                .status_rd  (status_rd[i]),
                .control_rd (control_rd[i]),
                .period_rd  (period_rd[i]),
                .snap_rd    (snap_rd[i]),
                .irq        (irq_vec[i])
            );
        end
    endgenerate

    always_comb begin
        read_value = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_STATUS:  read_value = status_rd[i];
                    REG_CONTROL: read_value = control_rd[i];
                    REG_PERIOD:  read_value = period_rd[i];
                    REG_SNAP:    read_value = snap_rd[i];
                    default:     read_value = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_value;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_snake_multi_timer.sv
// Scoreboard bench for snake_multi_timer: a behavioural channel model predicts every read and
// the IRQ lines; six channels leave indices 6 and 7 of the 3-bit channel field unpopulated.
module tb_snake_multi_timer;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 32;
    localparam int AW     = $clog2(NUM_CH) + 2;
    localparam logic [31:0] RST_PERIOD = 32'h0001D4BF;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    snake_multi_timer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RST_PERIOD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_vec    (irq_vec),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    typedef struct {
        logic [31:0] exp;
        bit          has_const;
        logic [31:0] cval;
        string       name;
    } rd_item_t;

    rd_item_t    sb[$];
    rd_item_t    new_item;
    rd_item_t    mon_item;
    bit          rd_due = 1'b0;
    bit          pend_has_const = 1'b0;
    logic [31:0] pend_cval = '0;
    string       pend_name = "";
    logic [NUM_CH-1:0] mon_exp;

    // Reference model: one entry per channel, updated once per clock.
    logic [31:0] m_period [NUM_CH];
    logic [31:0] m_count  [NUM_CH];
    logic [31:0] m_snap   [NUM_CH];
    logic [7:0]  m_presc  [NUM_CH];
    logic [7:0]  m_phase  [NUM_CH];
    bit          m_ito    [NUM_CH];
    bit          m_cont   [NUM_CH];
    bit          m_run    [NUM_CH];
    bit          m_to     [NUM_CH];
    bit          m_reload [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_period[c] = RST_PERIOD;
            m_count[c]  = RST_PERIOD;
            m_snap[c]   = '0;
            m_presc[c]  = '0;
            m_phase[c]  = '0;
            m_ito[c]    = 1'b0;
            m_cont[c]   = 1'b0;
            m_run[c]    = 1'b0;
            m_to[c]     = 1'b0;
            m_reload[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input int ch, input int rg);
        logic [31:0] v;
        v = '0;
        if (ch < NUM_CH) begin
            case (rg)
                0: v = {30'b0, m_run[ch], m_to[ch]};
                1: v = {16'b0, m_presc[ch], 6'b0, m_cont[ch], m_ito[ch]};
                2: v = m_period[ch];
                default: v = m_snap[ch];
            endcase
        end
        return v;
    endfunction

    task automatic model_step();
        bit wr;
        int ch;
        int rg;
        wr = chipselect && !write_n;
        ch = int'(address) >> 2;
        rg = int'(address) & 3;
        for (int c = 0; c < NUM_CH; c++) begin
            bit sel, start, stop, fires, expires, reload_now, was_running;
            logic [31:0] old_count;
            sel         = wr && (ch == c);
            start       = sel && rg == 1 && writedata[2];
            stop        = sel && rg == 1 && writedata[3];
            reload_now  = m_reload[c];
            was_running = m_run[c];
            old_count   = m_count[c];
            fires       = was_running && !reload_now && (m_phase[c] == m_presc[c]);
            expires     = fires && (old_count == 0);

            if (reload_now || expires) m_count[c] = m_period[c];
            else if (fires)            m_count[c] = old_count - 1;

            if (start || reload_now)   m_phase[c] = 0;
            else if (was_running)      m_phase[c] = fires ? 8'd0 : m_phase[c] + 8'd1;

            if (start)                                           m_run[c] = 1'b1;
            else if (reload_now || stop || (expires && !m_cont[c])) m_run[c] = 1'b0;

            if (expires)                m_to[c] = 1'b1;
            else if (sel && rg == 0)    m_to[c] = 1'b0;

            if (sel && rg == 3) m_snap[c] = old_count;
            if (sel && rg == 1) begin
                m_ito[c]   = writedata[0];
                m_cont[c]  = writedata[1];
                m_presc[c] = writedata[15:8];
            end
            m_reload[c] = sel && rg == 2;
            if (sel && rg == 2) m_period[c] = writedata;
        end
    endtask

    // Stimulus side of the scoreboard: reads push their predicted response.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
            rd_due = 1'b0;
            sb.delete();
        end else begin
            if (chipselect && write_n) begin
                new_item.exp       = model_read(int'(address) >> 2, int'(address) & 3);
                new_item.has_const = pend_has_const;
                new_item.cval      = pend_cval;
                new_item.name      = pend_name;
                sb.push_back(new_item);
                rd_due = 1'b1;
            end
            model_step();
        end
    end

    // Monitor: compares IRQ lines every cycle and pops a response when readdata is due.
    always @(negedge clk) begin
        if (started && reset_n) begin
            for (int c = 0; c < NUM_CH; c++) mon_exp[c] = m_to[c] & m_ito[c];
            check("irq_vec", 32'(irq_vec), 32'(mon_exp));
            check("irq", 32'(irq), 32'(|mon_exp));
            if (rd_due) begin
                rd_due = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_item = sb.pop_front();
                    check(mon_item.name, readdata, mon_item.exp);
                    if (mon_item.has_const)
                        check({mon_item.name, "_const"}, readdata, mon_item.cval);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input int ch, input int rg, input logic [31:0] data);
        address    = AW'((ch << 2) | rg);
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int rg, input bit hc, input logic [31:0] cv,
                            input string nm);
        address        = AW'((ch << 2) | rg);
        chipselect     = 1'b1;
        write_n        = 1'b1;
        pend_has_const = hc;
        pend_cval      = cv;
        pend_name      = nm;
        @(negedge clk);
        chipselect     = 1'b0;
        pend_has_const = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int          op, rch, rrg;
    logic [31:0] wd;

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        started = 1'b1;

        $display("[TB] reset values");
        for (int c = 0; c < NUM_CH; c++) begin
            bus_read(c, 0, 1, 32'h0, "rst_status");
            bus_read(c, 1, 1, 32'h0, "rst_control");
            bus_read(c, 2, 1, RST_PERIOD, "rst_period");
            bus_read(c, 3, 1, 32'h0, "rst_snap");
        end

        $display("[TB] continuous timeout on ch1");
        bus_write(1, 2, 32'd9);
        bus_write(1, 1, 32'h7);
        idle(9);
        check("t2_irq_before", 32'(irq_vec), 32'h0);
        idle(1);
        check("t2_irq_rise", 32'(irq_vec), 32'h2);
        bus_write(1, 0, 32'h0);
        check("t2_irq_clear", 32'(irq_vec), 32'h0);
        bus_write(1, 1, 32'h8);

        $display("[TB] one-shot with prescaler on ch0");
        bus_write(0, 2, 32'd3);
        bus_write(0, 1, 32'h0404);
        idle(19);
        bus_read(0, 0, 1, 32'h2, "t3_status_running");
        bus_read(0, 0, 1, 32'h1, "t3_status_done");
        bus_write(0, 3, 32'h0);
        bus_read(0, 3, 1, 32'd3, "t3_counter_reloaded");

        $display("[TB] stop, hold and resume on ch2");
        bus_write(2, 2, 32'd9);
        bus_write(2, 1, 32'h4);
        idle(3);
        bus_write(2, 1, 32'h8);
        idle(50);
        bus_write(2, 3, 32'h0);
        bus_read(2, 3, 1, 32'd5, "t4_snap_held");
        bus_write(2, 1, 32'h4);
        idle(2);
        bus_write(2, 3, 32'h0);
        bus_read(2, 3, 1, 32'd3, "t4_snap_resumed");

        $display("[TB] set beats clear, START beats STOP");
        bus_write(3, 2, 32'd2);
        bus_write(3, 1, 32'h6);
        idle(2);
        bus_write(3, 0, 32'h0);
        bus_read(3, 0, 1, 32'h3, "t5_to_survives_clear");
        bus_write(4, 1, 32'hC);
        bus_read(4, 0, 1, 32'h2, "t5_start_wins");

        $display("[TB] PERIOD write while running, unpopulated channels");
        bus_write(3, 2, 32'd100);
        bus_write(3, 0, 32'h0);
        bus_read(3, 0, 1, 32'h0, "t6_forced_stop");
        bus_write(3, 3, 32'h0);
        bus_read(3, 3, 1, 32'd100, "t6_counter_reload");
        bus_read(3, 2, 1, 32'd100, "t6_period");
        bus_write(7, 2, 32'h55);
        bus_write(6, 1, 32'h7);
        bus_read(7, 2, 1, 32'h0, "t6_ch7_period");
        bus_read(6, 1, 1, 32'h0, "t6_ch6_control");
        bus_read(3, 2, 1, 32'd100, "t6_ch3_untouched");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            op  = $urandom_range(0, 9);
            rch = $urandom_range(0, 7);
            rrg = $urandom_range(0, 3);
            if (op < 4) begin
                idle($urandom_range(1, 6));
            end else if (op < 7) begin
                wd = $urandom;
                if (rrg == 1) wd[15:8] = 8'($urandom_range(0, 3));
                if (rrg == 2) wd = $urandom_range(0, 12);
                bus_write(rch, rrg, wd);
            end else begin
                bus_read(rch, rrg, 0, 32'h0, "rand_rd");
            end
        end

        $display("[TB] level TO with PERIOD 0, then async reset");
        bus_write(1, 2, 32'd0);
        bus_write(1, 1, 32'h7);
        idle(1);
        check("t7_irq_level_on", 32'(irq_vec[1]), 32'h1);
        idle(3);
        check("t7_irq_level_held", 32'(irq_vec[1]), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_async_irq", 32'(irq), 32'h0);
        check("t7_async_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(1, 2, 1, RST_PERIOD, "t7_period_after_reset");
        bus_read(1, 1, 1, 32'h0, "t7_control_after_reset");
        bus_read(1, 0, 1, 32'h0, "t7_status_after_reset");

        idle(3);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
